// File: rtl/div_32_bits.sv
// Sequential unsigned restoring divider.
// One quotient bit is produced per clock by trial subtraction of the divisor
// from the shifted partial remainder. Operands are accepted on an
// in_valid/in_ready handshake and results are returned on an
// out_valid/out_ready handshake. A zero divisor skips the iterations and
// returns quotient = all ones and remainder = dividend, with div_by_zero set.
module div_32_bits #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_reg;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] d_reg;      // latched divisor
    logic [WIDTH:0]   r_reg;      // partial remainder, one extra bit for the trial subtract
    logic [CW-1:0]    count;
    logic             dbz_reg;
    logic             valid_reg;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;

    // Trial subtraction of the shifted remainder, done as an add of the
    // one's complement of the zero-extended divisor with carry-in of one.
    always_comb begin
        r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        trial   = r_shift + ~{1'b0, d_reg} + {{WIDTH{1'b0}}, 1'b1};
    end

    // Control FSM and datapath registers; outputs are taken directly from these.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            count     <= '0;
            dbz_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        count <= '0;
                        d_reg <= divisor;
                        if (divisor == '0) begin
                            // No iterations: canned divide-by-zero result.
                            q_reg     <= '1;
                            r_reg     <= {1'b0, dividend};
                            dbz_reg   <= 1'b1;
                            valid_reg <= 1'b1;
                            state     <= DONE;
                        end else begin
                            q_reg   <= dividend;
                            r_reg   <= '0;
                            dbz_reg <= 1'b0;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    // A set MSB means the trial went negative: keep the shifted remainder.
                    if (trial[WIDTH]) begin
                        r_reg <= r_shift;
                    end else begin
                        r_reg <= trial;
                    end
                    q_reg <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        valid_reg <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Results hold until the consumer takes them.
                    if (out_ready) begin
                        valid_reg <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = valid_reg;
    assign quotient    = q_reg;
    assign remainder   = r_reg[WIDTH-1:0];
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_32_bits.sv
// Directed and randomised checks for the sequential 32-bit divider.
module tb_div_32_bits;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    div_32_bits #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one operation after gap_in idle cycles, wait for the result, hold
    // out_ready low for gap_out cycles, then take it. Called and returning at
    // 1 time unit after a rising edge. lat counts rising edges after the
    // accept edge until out_valid is first seen (-1 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int gap_in, input int gap_out,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic z, output int lat);
        repeat (gap_in) begin
            @(posedge clk);
            #1;
        end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            lat = -1;
        end
        repeat (gap_out) begin
            @(posedge clk);
            #1;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("handshake_out_valid_low", {31'd0, out_valid}, 32'd0);
        check("handshake_in_ready_high", {31'd0, in_ready}, 32'd1);
    endtask

    vec_t        vecs [13];
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
    logic [31:0] hold_q;
    logic [31:0] hold_r;
    logic        seen_valid;

    initial begin
        // Hand-computed directed vectors.
        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[2]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
        vecs[4]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
        vecs[5]  = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        vecs[6]  = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};
        vecs[7]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[8]  = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0};
        vecs[9]  = '{32'h12345678,   32'h00000100,   32'h00123456,   32'h00000078,   1'b0};
        vecs[10] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
        vecs[11] = '{32'd1,          32'd2,          32'd0,          32'd1,          1'b0};
        vecs[12] = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, 0, q, r, z, lat);
            $display("vec %0d: %h / %h -> q=%h r=%h dbz=%0d lat=%0d", i, vecs[i].a, vecs[i].b, q, r, z, lat);
            check("vec_quotient", q, vecs[i].q);
            check("vec_remainder", r, vecs[i].r);
            check("vec_div_by_zero", {31'd0, z}, {31'd0, vecs[i].z});
            check("vec_latency", lat, (vecs[i].b == 0) ? 32'd0 : 32'd32);
        end

        // Backpressure: result held for 10 cycles, offers ignored meanwhile.
        dividend = 32'd100;
        divisor  = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", lat, 32'd32);
        hold_q = quotient;
        hold_r = remainder;
        check("bp_quotient", hold_q, 32'd14);
        check("bp_remainder", hold_r, 32'd2);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            dividend = 32'd50;
            divisor  = 32'd0;
            @(posedge clk);
            #1;
            check("bp_hold_quotient", quotient, hold_q);
            check("bp_hold_remainder", remainder, hold_r);
            check("bp_hold_dbz", {31'd0, div_by_zero}, 32'd0);
            check("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        $display("backpressure: held q=%h r=%h for 10 cycles", hold_q, hold_r);

        // Asynchronous reset in the middle of an operation.
        dividend = 32'd1000;
        divisor  = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        check("abort_in_ready_busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("abort_no_out_valid", {31'd0, seen_valid}, 32'd0);
        run_op(32'd1000, 32'd3, 0, 0, q, r, z, lat);
        $display("after abort: 1000 / 3 -> q=%0d r=%0d", q, r);
        check("abort_rerun_quotient", q, 32'd333);
        check("abort_rerun_remainder", r, 32'd1);

        // Random operand pairs with random handshake gaps.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [63:0] prod;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = a + 32'd1 + $urandom_range(0, 1000);
                2: b = 32'd1 << $urandom_range(0, 31);
                3: b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            run_op(a, b, $urandom_range(0, 3), $urandom_range(0, 3), q, r, z, lat);
            $display("rand %0d: %h / %h -> q=%h r=%h dbz=%0d", i, a, b, q, r, z);
            if (b == 0) begin
                check("rand_dbz_quotient", q, 32'hFFFFFFFF);
                check("rand_dbz_remainder", r, a);
                check("rand_dbz_flag", {31'd0, z}, 32'd1);
                check("rand_dbz_latency", lat, 32'd0);
            end else begin
                prod = 64'(q) * 64'(b) + 64'(r);
                check("rand_quotient", q, a / b);
                check("rand_remainder", r, a % b);
                check("rand_dbz_flag", {31'd0, z}, 32'd0);
                check("rand_identity", prod[31:0], a);
                check("rand_latency", lat, 32'd32);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
